branch_pred_ctrl: RTL and testbench

BRANCH_PRED_CTRL -- requirements
Module: branch_pred_ctrl

---
 rtl/branch_pred_ctrl.sv | 118 +++++++++++
 tb/tb_branch_pred_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/branch_pred_ctrl.sv
// Bimodal branch predictor with EX-stage redirect control.
// 2-bit saturating counters predict in IF; EX resolves, redirects and counts B-type mispredictions.
module branch_pred_ctrl #(
   parameter int IDX_W = 6,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_valid,
   input  logic [31:0]      if_pc,
   output logic             pred_taken,
   input  logic             ex_valid,
   input  logic [31:0]      ex_pc,
   input  logic [1:0]       ex_branch,
   input  logic             ex_zero_flag,
   input  logic             ex_pred_taken,
   output logic [1:0]       branch_ctrl,
   output logic             flush,
   output logic [CNT_W-1:0] mispredict_cnt
);

   localparam int ENTRIES = 1 << IDX_W;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_B    = 2'b01;
   localparam logic [1:0] BR_JALR = 2'b10;
   localparam logic [1:0] BR_J    = 2'b11;

   localparam logic [1:0] PC_4       = 2'b00;
   localparam logic [1:0] PC_IMM     = 2'b01;
   localparam logic [1:0] PC_IMMRS1  = 2'b10;
   localparam logic [1:0] PC_RECOVER = 2'b11;

   logic [1:0]       r_bht [ENTRIES];
   logic [CNT_W-1:0] r_cnt;

   logic [IDX_W-1:0] w_if_idx;
   logic [IDX_W-1:0] w_ex_idx;
   logic             w_is_b;
   logic [1:0]       w_cur;
   logic [1:0]       w_new;
   logic             w_unused;

   assign w_if_idx = if_pc[IDX_W+1:2];
   assign w_ex_idx = ex_pc[IDX_W+1:2];
   assign w_is_b   = ex_valid && (ex_branch == BR_B);
   assign w_unused = ^{if_pc[31:IDX_W+2], if_pc[1:0], ex_pc[31:IDX_W+2], ex_pc[1:0]};

   // Read of the registered table: a same-cycle update is not visible until the next edge.
   assign pred_taken = if_valid & r_bht[w_if_idx][1];

   assign w_cur = r_bht[w_ex_idx];

   always_comb begin
      w_new = w_cur;
      if (ex_zero_flag) begin
         if (w_cur != 2'b11) w_new = w_cur + 2'b01;
      end else begin
         if (w_cur != 2'b00) w_new = w_cur - 2'b01;
      end
   end

   always_comb begin
      branch_ctrl = PC_4;
      flush       = 1'b0;
      if (ex_valid) begin
         case (ex_branch)
            BR_B: begin
               if (ex_zero_flag && !ex_pred_taken) begin
                  branch_ctrl = PC_IMM;
                  flush       = 1'b1;
               end else if (!ex_zero_flag && ex_pred_taken) begin
                  branch_ctrl = PC_RECOVER;
                  flush       = 1'b1;
               end
            end
            BR_JALR: begin
               branch_ctrl = PC_IMMRS1;
               flush       = 1'b1;
            end
            BR_J: begin
               branch_ctrl = PC_IMM;
               flush       = 1'b1;
            end
            BR_NONE: begin
               branch_ctrl = PC_4;
               flush       = 1'b0;
            end
            default: begin
               branch_ctrl = PC_4;
               flush       = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) r_bht[i] <= 2'b01;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (w_is_b && (w_ex_idx == IDX_W'(i))) r_bht[i] <= w_new;
         end
      end
   end

   // Only B-type redirects are mispredictions; jumps flush but are not counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_is_b && flush && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign mispredict_cnt = r_cnt;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Scoreboard bench for branch_pred_ctrl: stimulus queues expectations from a table model,
// an independent monitor pops and compares on the falling edge.
module tb_branch_pred_ctrl;

   localparam int IDX_W = 6;
   localparam int CNT_W = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             if_valid = 1'b0;
   logic [31:0]      if_pc = '0;
   logic             pred_taken;
   logic             ex_valid = 1'b0;
   logic [31:0]      ex_pc = '0;
   logic [1:0]       ex_branch = '0;
   logic             ex_zero_flag = 1'b0;
   logic             ex_pred_taken = 1'b0;
   logic [1:0]       branch_ctrl;
   logic             flush;
   logic [CNT_W-1:0] mispredict_cnt;

   branch_pred_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_pc(if_pc), .pred_taken(pred_taken),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch(ex_branch),
      .ex_zero_flag(ex_zero_flag), .ex_pred_taken(ex_pred_taken),
      .branch_ctrl(branch_ctrl), .flush(flush), .mispredict_cnt(mispredict_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int pred;
      int ctrl;
      int fl;
      int cnt;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   txn   = 0;

   // Reference model: one confidence level 0..3 per table slot plus a count.
   int   m_bht [1 << IDX_W];
   int   m_cnt;

   task automatic model_reset();
      for (int i = 0; i < (1 << IDX_W); i++) m_bht[i] = 1;
      m_cnt = 0;
   endtask

   task automatic check(input string name, input int id, input logic [31:0] act, input int want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s txn=%0d got=%0d want=%0d", name, id, act, want);
      end
   endtask

   // One cycle of stimulus: inputs applied 1ns after the rising edge.
   task automatic drive(input logic r, input logic iv, input logic [31:0] ipc,
                        input logic ev, input logic [31:0] epc, input logic [1:0] br,
                        input logic z, input logic p);
      exp_t e;
      int   slot_if;
      int   slot_ex;
      bit   is_b;
      @(posedge clk);
      #1;
      rst = r; if_valid = iv; if_pc = ipc;
      ex_valid = ev; ex_pc = epc; ex_branch = br; ex_zero_flag = z; ex_pred_taken = p;
      if (r) model_reset();
      slot_if = int'((ipc / 4) % (1 << IDX_W));
      slot_ex = int'((epc / 4) % (1 << IDX_W));
      is_b = ev && (br == 2'd1);
      e.id   = txn++;
      e.pred = (iv && m_bht[slot_if] >= 2) ? 1 : 0;
      e.cnt  = m_cnt;
      e.ctrl = 0;
      e.fl   = 0;
      if (ev) begin
         if (br == 2'd2) begin e.ctrl = 2; e.fl = 1; end
         else if (br == 2'd3) begin e.ctrl = 1; e.fl = 1; end
         else if (br == 2'd1 && z != p) begin e.ctrl = z ? 1 : 3; e.fl = 1; end
      end
      sb.push_back(e);
      if (!r && is_b) begin
         if (z) m_bht[slot_ex] = (m_bht[slot_ex] == 3) ? 3 : m_bht[slot_ex] + 1;
         else   m_bht[slot_ex] = (m_bht[slot_ex] == 0) ? 0 : m_bht[slot_ex] - 1;
         if (e.fl == 1) m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
      end
   endtask

   task automatic idle(input logic iv, input logic [31:0] ipc);
      drive(1'b0, iv, ipc, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
   endtask

   task automatic b_op(input logic [31:0] epc, input logic z, input logic p);
      drive(1'b0, 1'b0, 32'h0, 1'b1, epc, 2'b01, z, p);
   endtask

   // Monitor: outputs are combinational, so every driven cycle is a transaction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            $display("txn %0d: pred=%0b ctrl=%0d flush=%0b cnt=%0d", e.id, pred_taken,
                     branch_ctrl, flush, mispredict_cnt);
            check("pred_taken", e.id, {31'b0, pred_taken}, e.pred);
            check("branch_ctrl", e.id, {30'b0, branch_ctrl}, e.ctrl);
            check("flush", e.id, {31'b0, flush}, e.fl);
            check("mispredict_cnt", e.id, {{(32-CNT_W){1'b0}}, mispredict_cnt}, e.cnt);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog txn=%0d got=timeout want=finish", txn);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int wait_cycles;
      logic [31:0] pc;
      model_reset();
      // Reset held; an in-flight B update must be discarded.
      drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h40, 2'b01, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h40, 2'b01, 1'b1, 1'b0);
      idle(1'b1, 32'h40);
      // Training at 0x40: 01 -> 10 -> 11.
      b_op(32'h40, 1'b1, 1'b0);
      b_op(32'h40, 1'b1, 1'b1);
      idle(1'b1, 32'h40);
      // Wrong-taken prediction recovers to ex_pc+4.
      b_op(32'h40, 1'b0, 1'b1);
      idle(1'b1, 32'h40);
      // Saturation at 0x80, then a taken with pred=0.
      for (int i = 0; i < 5; i++) b_op(32'h80, 1'b0, 1'b0);
      b_op(32'h80, 1'b1, 1'b0);
      idle(1'b1, 32'h80);
      b_op(32'h80, 1'b1, 1'b0);
      idle(1'b1, 32'h80);
      // Jumps flush without counting or training.
      drive(1'b0, 1'b1, 32'h0, 1'b1, 32'h0, 2'b10, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 32'h0, 1'b1, 32'h0, 2'b11, 1'b1, 1'b0);
      idle(1'b1, 32'h0);
      // Aliasing: 0x100 shares the slot of 0x0.
      b_op(32'h100, 1'b1, 1'b0);
      idle(1'b1, 32'h0);
      // Same-cycle read and update of an untrained slot.
      drive(1'b0, 1'b1, 32'h44, 1'b1, 32'h44, 2'b01, 1'b1, 1'b0);
      idle(1'b1, 32'h44);
      // Mid-run reset pulse, then sweep every slot.
      drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h44, 2'b01, 1'b1, 1'b1);
      for (int a = 0; a < 64; a++) idle(1'b1, 32'(a * 4));
      // Randomized traffic over a small hot set plus random aliases.
      for (int i = 0; i < 400; i++) begin
         pc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7) * 4);
         drive(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) == 1) ? pc : 32'($urandom_range(0, 7) * 4),
               ($urandom_range(0, 5) != 0) ? 1'b1 : 1'b0,
               pc,
               ($urandom_range(0, 4) < 3) ? 2'b01 : 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end
      idle(1'b0, 32'h0);
      wait_cycles = 0;
      while (sb.size() > 0 && wait_cycles < 20) begin
         @(posedge clk);
         wait_cycles++;
      end
      if (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain got=%0d pending want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
